conv_frame_seq: RTL and testbench
=================================

Name: conv_frame_seq

Overview:
Frame-level sequencer for the streaming convolution datapath. It accepts one XS x XS frame of pixels per start command through a valid/ready handshake and drives the line-buffer write enable. It flags every accepted pixel that completes a WS x WS window on the STRIDE grid, together with that window's output coordinates. It also tracks the MAC pipeline latency and pulses frame-done once the last result has left the datapath.

Parameters:
XS, 32, frame width and height in pixels (square frame)
WS, 5, window size; WS <= XS
STRIDE, 1, window step in both directions; >= 1
PIPE, 3, MAC datapath latency in cycles from window-valid to result-valid; >= 1
CW, $clog2(XS), counter and coordinate width (derived; not overridden)

Ports:
iCLK  input  1  clock, all state on rising edge
iRSTn  input  1  asynchronous active-low reset
iStart  input  1  start one frame; honoured only in IDLE
iClear  input  1  synchronous abort; highest priority after reset
iValid  input  1  upstream pixel valid
oReady  output  1  sequencer can accept a pixel
iDownReady  input  1  downstream/line buffer can take a pixel
oPixWr  output  1  line-buffer write/shift enable (= accepted pixel)
oWinValid  output  1  accepted pixel completes an on-grid window
oOutRow  output  CW  output row index of the current window
oOutCol  output  CW  output column index of the current window
oResValid  output  1  oWinValid delayed PIPE cycles (MAC result valid)
oBusy  output  1  state != IDLE
oFrameDone  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: every output is 0. State is IDLE. Pixel row/col counters are 0. Next-window row/col registers are WS-1. Output row/col are 0. Delay line is cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on iStart; counters are re-initialised on this transition.
  - RUN -> DRAIN on acceptance of the pixel at row XS-1, col XS-1.
  - DRAIN -> DONE after exactly PIPE cycles, counted by a drain counter.
  - DONE -> IDLE unconditionally; oFrameDone = 1 only in DONE.
- iStart outside IDLE is ignored. iClear in any state: next state IDLE, counters and delay line cleared, no oFrameDone.
- Handshake:
  - oReady = (state==RUN) & iDownReady, combinational.
  - accept = iValid & oReady.
  - oPixWr = accept.
  - Counters advance only on accept. A stall (iValid=0 or iDownReady=0) holds all counters.
- Pixel counters:
  - col wraps XS-1 -> 0 and increments row.
  - row does not wrap in RUN; the frame ends at (XS-1, XS-1).
- Window detection: use next-position registers only, no modulo or divide.
  - oWinValid = accept & (row==row_next) & (col==col_next), combinational.
  - On a window hit: if col_next+STRIDE <= XS-1, col_next += STRIDE; otherwise col_next stays put for the rest of the row (no further match).
  - On accept at col==XS-1 with row==row_next: col_next reloads to WS-1; row_next += STRIDE when row_next+STRIDE <= XS-1, otherwise it is parked at a value unreachable within the frame.
- Output coordinates:
  - oOutCol increments on each window hit and resets to 0 at end of row.
  - oOutRow increments after the last window of an active row.
  - Both are valid only while oWinValid = 1. They are combinational from registered output-index counters.
- Window counts: OS = (XS-WS)/STRIDE + 1 per axis, so OS*OS windows per frame. Last window col = WS-1 + (OS-1)*STRIDE.
- oResValid: PIPE-deep shift register of oWinValid. It free-runs, because the stall is applied at the input. It is cleared by reset or iClear.
- Simultaneous events:
  - iStart with iClear in IDLE: iClear wins, stay IDLE.
  - Final accept: the DRAIN transition and its window hit occur in the same cycle.
- Reset asserted mid-frame aborts immediately, asynchronously; no partial-frame done pulse.

Decomposition:
- Shared package conv_pkg: state enum (IDLE/RUN/DRAIN/DONE), function computing OS from XS/WS/STRIDE, CW derivation. Shared with the datapath and line buffer.
- Sub-module conv_win_track: pixel counters plus next-position logic producing hit, oOutRow and oOutCol. Instantiated once; the top holds the FSM, handshake and delay line.

Test Plan:
- XS=32, WS=5, STRIDE=1, iValid and iDownReady held 1, one iStart:
  - 1024 oPixWr;
  - first oWinValid on accepted pixel #133 (row 4, col 4) with out (0,0);
  - 784 oWinValid, last at out (27,27);
  - oResValid count 784;
  - oFrameDone one cycle, PIPE+1 cycles after the last accept.
- STRIDE=2, XS=32, WS=5: 196 windows; cols hit 4,6,...,30 and never 31; out coordinates span 0..13.
- Random iValid/iDownReady toggling (50%): same window sequence and coordinates as the no-stall run; no counter movement on any non-accept cycle.
- iStart pulsed during RUN and DRAIN: ignored; window count still 784; exactly one oFrameDone.
- iClear at pixel 500: next cycle oBusy=0, oReady=0, oResValid=0, no oFrameDone; a following iStart gives a clean full frame (first window at pixel #133).
- iRSTn low at pixel 300 then released: all outputs 0 during reset; the next frame is correct from out (0,0).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution datapath.
// No timing of its own; imported by sequencer, window tracker, line buffer and MAC.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic int cw_of(input int xs);
    return (xs > 1) ? $clog2(xs) : 1;
  endfunction

  // Output windows per axis for a square frame.
  function automatic int os_of(input int xs, input int ws, input int stride);
    return (xs - ws) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_win_track.sv
// Pixel position counters and on-grid window detection; hit is combinational from acc_i.
// Advances only on acc_i, so upstream stalls simply freeze all position state.
module conv_win_track
  import conv_pkg::*;
#(
  parameter  int XS     = 32,
  parameter  int WS     = 5,
  parameter  int STRIDE = 1,
  localparam int CW     = cw_of(XS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          init_i,
  input  logic          clear_i,
  input  logic          acc_i,
  output logic          hit_o,
  output logic          last_pix_o,
  output logic [CW-1:0] out_row_o,
  output logic [CW-1:0] out_col_o
);

  // One extra bit so the parked row target (XS) can never equal a real row.
  localparam int            NW   = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(XS - 1);
  localparam logic [NW-1:0] WIN0 = NW'(WS - 1);
  localparam logic [NW-1:0] PARK = NW'(XS);
  localparam logic [NW-1:0] STEP = NW'(STRIDE);

  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [NW-1:0] rnext_q, rnext_d, cnext_q, cnext_d;
  logic          row_act, eol;

  assign row_act    = ({1'b0, row_q} == rnext_q);
  assign eol        = (col_q == LAST);
  assign hit_o      = acc_i & row_act & ({1'b0, col_q} == cnext_q);
  assign last_pix_o = eol & (row_q == LAST);
  assign out_row_o  = orow_q;
  assign out_col_o  = ocol_q;

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    rnext_d = rnext_q;
    cnext_d = cnext_q;
    if (acc_i) begin
      if (eol) begin
        col_d = '0;
        if (row_q != LAST) row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (hit_o) begin
        ocol_d = ocol_q + 1'b1;
        if (int'(cnext_q) + STRIDE <= XS - 1) cnext_d = cnext_q + STEP;
      end
      // End-of-row handling overrides the hit update when both fall on col XS-1.
      if (eol) begin
        ocol_d = '0;
        if (row_act) begin
          cnext_d = WIN0;
          orow_d  = orow_q + 1'b1;
          rnext_d = (int'(rnext_q) + STRIDE <= XS - 1) ? rnext_q + STEP : PARK;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_q   <= '0;
      col_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      rnext_q <= WIN0;
      cnext_q <= WIN0;
    end else if (clear_i || init_i) begin
      row_q   <= '0;
      col_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      rnext_q <= WIN0;
      cnext_q <= WIN0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      rnext_q <= rnext_d;
      cnext_q <= cnext_d;
    end
  end

endmodule

// File: rtl/conv_frame_seq.sv
// Frame sequencer: accepts XS*XS pixels per start, flags windows, pulses done PIPE+1 cycles after last accept.
// oReady is combinational from state and iDownReady; stalls freeze counters, the result delay line free-runs.
module conv_frame_seq
  import conv_pkg::*;
#(
  parameter  int XS     = 32,
  parameter  int WS     = 5,
  parameter  int STRIDE = 1,
  parameter  int PIPE   = 3,
  localparam int CW     = cw_of(XS)
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic          iClear,
  input  logic          iValid,
  output logic          oReady,
  input  logic          iDownReady,
  output logic          oPixWr,
  output logic          oWinValid,
  output logic [CW-1:0] oOutRow,
  output logic [CW-1:0] oOutCol,
  output logic          oResValid,
  output logic          oBusy,
  output logic          oFrameDone
);

  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  seq_state_e    state_q;
  logic [DW-1:0] drain_q;
  logic          done_q;
  logic [PIPE-1:0] sr_q;
  logic [PIPE:0]   sr_ext;
  logic          accept, hit, last_pix, init;

  assign oReady     = (state_q == ST_RUN) & iDownReady;
  assign accept     = iValid & oReady;
  assign oPixWr     = accept;
  assign oWinValid  = hit;
  assign oResValid  = sr_q[PIPE-1];
  assign oBusy      = (state_q != ST_IDLE);
  assign oFrameDone = done_q;
  assign init       = (state_q == ST_IDLE) & iStart & ~iClear;
  assign sr_ext     = {sr_q, hit};

  conv_win_track #(
    .XS     (XS),
    .WS     (WS),
    .STRIDE (STRIDE)
  ) u_win_track (
    .clk_i      (iCLK),
    .rst_n_i    (iRSTn),
    .init_i     (init),
    .clear_i    (iClear),
    .acc_i      (accept),
    .hit_o      (hit),
    .last_pix_o (last_pix),
    .out_row_o  (oOutRow),
    .out_col_o  (oOutCol)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      sr_q    <= '0;
    end else if (iClear) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      sr_q   <= sr_ext[PIPE-1:0];
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iStart) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (accept && last_pix) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        // Hold off done until the final window's result has left the MAC pipe.
        ST_DRAIN: begin
          if (drain_q == DW'(PIPE - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_seq.sv
// Randomised bench: two sequencers (stride 1 and 2) share stimulus and are checked every cycle
// against a pixel-index reference model built from divide/modulo window arithmetic.
module tb_conv_frame_seq;

  localparam int XS   = 32;
  localparam int WS   = 5;
  localparam int PIPE = 3;
  localparam int CW   = 5;
  localparam int NPIX = XS * XS;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, clear = 1'b0, valid = 1'b0, dready = 1'b0;

  logic          g_rdy[2], g_pw[2], g_wv[2], g_rv[2], g_bz[2], g_fd[2];
  logic [CW-1:0] g_or[2], g_oc[2];

  int stride_of[2] = '{1, 2};

  always #5 clk = ~clk;

  conv_frame_seq #(.XS(XS), .WS(WS), .STRIDE(1), .PIPE(PIPE)) dut0 (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start), .iClear(clear), .iValid(valid),
    .oReady(g_rdy[0]), .iDownReady(dready), .oPixWr(g_pw[0]), .oWinValid(g_wv[0]),
    .oOutRow(g_or[0]), .oOutCol(g_oc[0]), .oResValid(g_rv[0]), .oBusy(g_bz[0]),
    .oFrameDone(g_fd[0])
  );

  conv_frame_seq #(.XS(XS), .WS(WS), .STRIDE(2), .PIPE(PIPE)) dut1 (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start), .iClear(clear), .iValid(valid),
    .oReady(g_rdy[1]), .iDownReady(dready), .oPixWr(g_pw[1]), .oWinValid(g_wv[1]),
    .oOutRow(g_or[1]), .oOutCol(g_oc[1]), .oResValid(g_rv[1]), .oBusy(g_bz[1]),
    .oFrameDone(g_fd[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_win(input int p, input int s, output int orow, output int ocol);
    int r, c, os;
    r = p / XS;
    c = p % XS;
    os = (XS - WS) / s + 1;
    orow = 0;
    ocol = 0;
    if (r < WS - 1 || c < WS - 1) return 1'b0;
    if ((r - WS + 1) % s != 0 || (c - WS + 1) % s != 0) return 1'b0;
    orow = (r - WS + 1) / s;
    ocol = (c - WS + 1) / s;
    return (orow < os) && (ocol < os);
  endfunction

  // Reference model state
  int cyc = 0;
  bit m_active = 1'b0, m_run = 1'b0;
  int m_pix = 0;
  int m_done_cyc = -1;
  int res_due[2][$];
  int wins_seen[2], res_seen[2];
  int done_seen = 0;
  bit exp_rdy, exp_pw;
  bit ew[2];
  int er, ec, os_n;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("reset_outputs", {g_rdy[d], g_pw[d], g_wv[d], g_rv[d], g_bz[d], g_fd[d], g_or[d], g_oc[d]}, 0);
        res_due[d].delete();
      end
      m_active = 1'b0;
      m_run = 1'b0;
      m_pix = 0;
      m_done_cyc = -1;
    end else begin
      exp_rdy = m_run & dready;
      exp_pw  = exp_rdy & valid;
      for (int d = 0; d < 2; d++) begin
        chk("ready", g_rdy[d], exp_rdy);
        chk("pixwr", g_pw[d], exp_pw);
        chk("busy", g_bz[d], m_active);
        chk("frame_done", g_fd[d], m_active && (cyc == m_done_cyc));
        ew[d] = exp_pw && is_win(m_pix, stride_of[d], er, ec);
        chk("win_valid", g_wv[d], ew[d]);
        if (ew[d] && g_wv[d]) begin
          chk("out_row", g_or[d], er);
          chk("out_col", g_oc[d], ec);
        end
        if (res_due[d].size() > 0 && res_due[d][0] == cyc) begin
          void'(res_due[d].pop_front());
          chk("res_valid", g_rv[d], 1);
        end else begin
          chk("res_valid", g_rv[d], 0);
        end
        if (g_wv[d]) wins_seen[d]++;
        if (g_rv[d]) res_seen[d]++;
        if (m_active && cyc == m_done_cyc) begin
          os_n = (XS - WS) / stride_of[d] + 1;
          chk("win_count", wins_seen[d], os_n * os_n);
          chk("res_count", res_seen[d], os_n * os_n);
        end
      end
      if (g_fd[0]) done_seen++;

      if (clear) begin
        m_active = 1'b0;
        m_run = 1'b0;
        m_pix = 0;
        m_done_cyc = -1;
        for (int d = 0; d < 2; d++) res_due[d].delete();
      end else begin
        for (int d = 0; d < 2; d++) if (ew[d]) res_due[d].push_back(cyc + PIPE);
        if (m_active && cyc == m_done_cyc) begin
          m_active = 1'b0;
        end else if (!m_active && start) begin
          m_active = 1'b1;
          m_run = 1'b1;
          m_pix = 0;
          wins_seen = '{0, 0};
          res_seen = '{0, 0};
        end else if (m_run && exp_pw) begin
          m_pix++;
          if (m_pix == NPIX) begin
            m_run = 1'b0;
            m_done_cyc = cyc + PIPE + 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit stall, input bit poke);
    int budget, d0;
    bit poked1, poked2;
    budget = 0;
    d0 = done_seen;
    poked1 = 1'b0;
    poked2 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (m_active && budget < 20000) begin
      valid  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      dready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      start  = 1'b0;
      if (poke && !poked1 && m_pix >= 200) begin
        start = 1'b1;
        poked1 = 1'b1;
      end
      if (poke && !poked2 && m_active && !m_run) begin
        start = 1'b1;
        poked2 = 1'b1;
      end
      step();
      budget++;
    end
    start = 1'b0;
    valid = 1'b0;
    dready = 1'b0;
    chk("frame_timeout", m_active, 0);
    step();
    chk("done_pulses", done_seen - d0, 1);
  endtask

  task automatic abort_at(input int npx, input bit use_rst);
    int budget, d0;
    budget = 0;
    d0 = done_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b1;
    dready = 1'b1;
    while (m_pix < npx && budget < 5000) begin
      step();
      budget++;
    end
    chk("abort_reach", (m_pix >= npx), 1);
    if (use_rst) begin
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
    end else begin
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk("clear_busy", g_bz[d], 0);
        chk("clear_ready", g_rdy[d], 0);
        chk("clear_res", g_rv[d], 0);
      end
    end
    valid = 1'b0;
    dready = 1'b0;
    repeat (PIPE + 3) step();
    chk("abort_no_done", done_seen - d0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    abort_at(500, 1'b0);
    run_frame(1'b0, 1'b0);
    abort_at(300, 1'b1);
    run_frame(1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
